// File: rtl/systolic_array_os.sv
// Output-stationary ROWS x COLS signed MAC array with internal input skew, optional bias
// preload, optional saturation and a back-pressured row-by-row result drain.
module systolic_array_os #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 32,
    parameter int SATURATE = 0
) (
    input  logic                    s_clk,
    input  logic                    s_rst,
    input  logic                    acc_mode,
    input  logic                    MtrxA_slice_valid,
    input  logic [ROWS*DATA_W-1:0]  MtrxA_slice_data,
    input  logic                    MtrxA_slice_done,
    output logic                    MtrxA_slice_ready,
    input  logic                    MtrxB_slice_valid,
    input  logic [COLS*DATA_W-1:0]  MtrxB_slice_data,
    input  logic                    MtrxB_slice_done,
    output logic                    MtrxB_slice_ready,
    input  logic                    MtrxC_slice_valid,
    input  logic [COLS*ACC_W-1:0]   MtrxC_slice_data,
    output logic                    MtrxC_slice_ready,
    output logic                    Result_valid,
    output logic [COLS*ACC_W-1:0]   Result_data,
    output logic                    Result_last,
    input  logic                    Result_ready,
    output logic                    busy,
    output logic                    err
);

    localparam int PROD_W    = 2 * DATA_W;
    localparam int SUM_W     = ACC_W + 1;
    localparam int FLUSH_LEN = ROWS + COLS - 1;
    localparam int FC_W      = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
    localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [2:0] {IDLE, LOAD_C, STREAM, FLUSH, OUTPUT} state_t;

    state_t             state;
    logic               live;
    logic               busy_q;
    logic               res_valid_q;
    logic               err_q;
    logic [ROW_W-1:0]   row_cnt;
    logic [FC_W-1:0]    flush_cnt;

    logic ab_ready, c_ready, consume, c_take, done_any;
    logic last_row, out_fire, clear_acc, accum_en;

    logic signed [DATA_W-1:0] a_gate [ROWS];
    logic signed [DATA_W-1:0] b_gate [COLS];
    logic signed [DATA_W-1:0] a_skew [ROWS];
    logic signed [DATA_W-1:0] b_skew [COLS];
    logic signed [DATA_W-1:0] a_pipe [ROWS][COLS];
    logic signed [DATA_W-1:0] b_pipe [ROWS][COLS];
    logic signed [ACC_W-1:0]  acc    [ROWS][COLS];

    function automatic logic signed [ACC_W-1:0] mac(
        input logic signed [ACC_W-1:0]  acc_v,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [PROD_W-1:0] prod;
        logic signed [SUM_W-1:0]  sum;
        prod = PROD_W'(a) * PROD_W'(b);
        sum  = SUM_W'(acc_v) + SUM_W'(prod);
        // The extra sum bit disagrees with the sign bit exactly when ACC_W overflowed.
        if (SATURATE != 0 && sum[ACC_W] != sum[ACC_W-1])
            return sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return sum[ACC_W-1:0];
    endfunction

    // live holds every ready low while reset is applied and for the first edge after it.
    assign ab_ready  = live && ((state == IDLE && !acc_mode) || state == STREAM);
    assign c_ready   = live && ((state == IDLE && acc_mode) || state == LOAD_C);
    assign consume   = ab_ready && MtrxA_slice_valid && MtrxB_slice_valid;
    assign c_take    = c_ready && MtrxC_slice_valid;
    assign done_any  = MtrxA_slice_done || MtrxB_slice_done;
    assign last_row  = (row_cnt == ROW_W'(ROWS - 1));
    assign out_fire  = res_valid_q && Result_ready;
    assign clear_acc = out_fire && last_row;
    assign accum_en  = (state == STREAM) || (state == FLUSH);

    assign MtrxA_slice_ready = ab_ready;
    assign MtrxB_slice_ready = ab_ready;
    assign MtrxC_slice_ready = c_ready;
    assign Result_valid      = res_valid_q;
    assign Result_last       = res_valid_q && last_row;
    assign busy              = busy_q;
    assign err               = err_q;

    // Bubbles inject zeros so the skewed wavefront never picks up stale operands.
    // NOTE: every variable in always_comb gets a value on every path, or a latch is inferred.
    always_comb begin
        for (int r = 0; r < ROWS; r++) a_gate[r] = '0;
        for (int c = 0; c < COLS; c++) b_gate[c] = '0;
        if (consume) begin
            for (int r = 0; r < ROWS; r++) a_gate[r] = $signed(MtrxA_slice_data[r*DATA_W +: DATA_W]);
            for (int c = 0; c < COLS; c++) b_gate[c] = $signed(MtrxB_slice_data[c*DATA_W +: DATA_W]);
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
        if (r == 0) begin : g_direct
            assign a_skew[r] = a_gate[r];
        end else begin : g_delay
            logic signed [DATA_W-1:0] dly [r];
            // NOTE: non-blocking assignments make the shift chain move one stage per edge.
            always_ff @(posedge s_clk or negedge s_rst) begin
                if (!s_rst) begin
                    for (int i = 0; i < r; i++) dly[i] <= '0;
                end else begin
                    dly[0] <= a_gate[r];
                    for (int i = 1; i < r; i++) dly[i] <= dly[i-1];
                end
            end
            assign a_skew[r] = dly[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_b_skew
        if (c == 0) begin : g_direct
            assign b_skew[c] = b_gate[c];
        end else begin : g_delay
            logic signed [DATA_W-1:0] dly [c];
            always_ff @(posedge s_clk or negedge s_rst) begin
                if (!s_rst) begin
                    for (int i = 0; i < c; i++) dly[i] <= '0;
                end else begin
                    dly[0] <= b_gate[c];
                    for (int i = 1; i < c; i++) dly[i] <= dly[i-1];
                end
            end
            assign b_skew[c] = dly[c-1];
        end
    end

    // A flows right along each row, B flows down each column; each PE works on its registered pair.
    // NOTE: the accumulator grid is functional state and must come out of reset cleared.
    always_ff @(posedge s_clk or negedge s_rst) begin
        if (!s_rst) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    a_pipe[r][c] <= '0;
                    b_pipe[r][c] <= '0;
                    acc[r][c]    <= '0;
                end
            end
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                a_pipe[r][0] <= a_skew[r];
                for (int c = 1; c < COLS; c++) a_pipe[r][c] <= a_pipe[r][c-1];
            end
            for (int c = 0; c < COLS; c++) begin
                b_pipe[0][c] <= b_skew[c];
                for (int r = 1; r < ROWS; r++) b_pipe[r][c] <= b_pipe[r-1][c];
            end
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (clear_acc)
                        acc[r][c] <= '0;
                    else if (c_take && row_cnt == ROW_W'(r))
                        acc[r][c] <= $signed(MtrxC_slice_data[c*ACC_W +: ACC_W]);
                    else if (accum_en)
                        acc[r][c] <= mac(acc[r][c], a_pipe[r][c], b_pipe[r][c]);
                end
            end
        end
    end

    always_ff @(posedge s_clk or negedge s_rst) begin
        if (!s_rst) begin
            state       <= IDLE;
            live        <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            row_cnt     <= '0;
            flush_cnt   <= '0;
        end else begin
            live <= 1'b1;
            if (consume && done_any && (MtrxA_slice_done != MtrxB_slice_done))
                err_q <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (c_take) begin
                        busy_q <= 1'b1;
                        if (ROWS == 1) begin
                            state <= STREAM;
                        end else begin
                            state   <= LOAD_C;
                            row_cnt <= ROW_W'(1);
                        end
                    end else if (consume) begin
                        busy_q    <= 1'b1;
                        flush_cnt <= '0;
                        state     <= done_any ? FLUSH : STREAM;
                    end
                end
                LOAD_C: begin
                    if (c_take) begin
                        if (last_row) begin
                            row_cnt <= '0;
                            state   <= STREAM;
                        end else begin
                            row_cnt <= row_cnt + ROW_W'(1);
                        end
                    end
                end
                STREAM: begin
                    if (consume && done_any) begin
                        flush_cnt <= '0;
                        state     <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FC_W'(FLUSH_LEN - 1)) begin
                        res_valid_q <= 1'b1;
                        state       <= OUTPUT;
                    end else begin
                        flush_cnt <= flush_cnt + FC_W'(1);
                    end
                end
                OUTPUT: begin
                    if (out_fire) begin
                        if (last_row) begin
                            row_cnt     <= '0;
                            res_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            row_cnt <= row_cnt + ROW_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        Result_data = '0;
        if (res_valid_q)
            for (int c = 0; c < COLS; c++) Result_data[c*ACC_W +: ACC_W] = acc[row_cnt][c];
    end

endmodule

// File: tb/tb_systolic_array_os.sv
// Scoreboard bench: three 2x2 instances (32-bit wrap, 16-bit saturate, 16-bit wrap) share
// one stimulus stream; a reference model queues expected rows that monitors pop on handshake.
module tb_systolic_array_os;

    localparam int R   = 2;
    localparam int C   = 2;
    localparam int DW  = 8;
    localparam int AW  = 32;
    localparam int AWS = 16;

    typedef struct packed {
        logic           last;
        logic [C*64-1:0] v;
    } row_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              acc_mode, a_valid, a_done, b_valid, b_done, c_valid, res_ready;
    logic [R*DW-1:0]   a_data;
    logic [C*DW-1:0]   b_data;
    logic [C*AW-1:0]   c_data;
    logic [C*AWS-1:0]  c_data16;

    logic a_rdy_m, b_rdy_m, c_rdy_m, valid_m, last_m, busy_m, err_m;
    logic a_rdy_s, b_rdy_s, c_rdy_s, valid_s, last_s, busy_s, err_s;
    logic a_rdy_w, b_rdy_w, c_rdy_w, valid_w, last_w, busy_w, err_w;
    logic [C*AW-1:0]  data_m;
    logic [C*AWS-1:0] data_s, data_w;

    systolic_array_os #(.ROWS(R), .COLS(C), .DATA_W(DW), .ACC_W(AW), .SATURATE(0)) dut_main (
        .s_clk(clk), .s_rst(rst_n), .acc_mode(acc_mode),
        .MtrxA_slice_valid(a_valid), .MtrxA_slice_data(a_data), .MtrxA_slice_done(a_done), .MtrxA_slice_ready(a_rdy_m),
        .MtrxB_slice_valid(b_valid), .MtrxB_slice_data(b_data), .MtrxB_slice_done(b_done), .MtrxB_slice_ready(b_rdy_m),
        .MtrxC_slice_valid(c_valid), .MtrxC_slice_data(c_data), .MtrxC_slice_ready(c_rdy_m),
        .Result_valid(valid_m), .Result_data(data_m), .Result_last(last_m), .Result_ready(res_ready),
        .busy(busy_m), .err(err_m)
    );

    systolic_array_os #(.ROWS(R), .COLS(C), .DATA_W(DW), .ACC_W(AWS), .SATURATE(1)) dut_sat (
        .s_clk(clk), .s_rst(rst_n), .acc_mode(acc_mode),
        .MtrxA_slice_valid(a_valid), .MtrxA_slice_data(a_data), .MtrxA_slice_done(a_done), .MtrxA_slice_ready(a_rdy_s),
        .MtrxB_slice_valid(b_valid), .MtrxB_slice_data(b_data), .MtrxB_slice_done(b_done), .MtrxB_slice_ready(b_rdy_s),
        .MtrxC_slice_valid(c_valid), .MtrxC_slice_data(c_data16), .MtrxC_slice_ready(c_rdy_s),
        .Result_valid(valid_s), .Result_data(data_s), .Result_last(last_s), .Result_ready(res_ready),
        .busy(busy_s), .err(err_s)
    );

    systolic_array_os #(.ROWS(R), .COLS(C), .DATA_W(DW), .ACC_W(AWS), .SATURATE(0)) dut_wrap (
        .s_clk(clk), .s_rst(rst_n), .acc_mode(acc_mode),
        .MtrxA_slice_valid(a_valid), .MtrxA_slice_data(a_data), .MtrxA_slice_done(a_done), .MtrxA_slice_ready(a_rdy_w),
        .MtrxB_slice_valid(b_valid), .MtrxB_slice_data(b_data), .MtrxB_slice_done(b_done), .MtrxB_slice_ready(b_rdy_w),
        .MtrxC_slice_valid(c_valid), .MtrxC_slice_data(c_data16), .MtrxC_slice_ready(c_rdy_w),
        .Result_valid(valid_w), .Result_data(data_w), .Result_last(last_w), .Result_ready(res_ready),
        .busy(busy_w), .err(err_w)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   t_acc    = 0;
    logic err_exp  = 1'b0;
    int   ta [16][R];
    int   tb [16][C];
    int   tc [R][C];
    row_t q_m[$], q_s[$], q_w[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic longint step(input longint acc, input longint prod, input int w, input bit sat);
        longint s, maxv, minv, t;
        s    = acc + prod;
        maxv = (64'sd1 <<< (w - 1)) - 1;
        minv = -(64'sd1 <<< (w - 1));
        if (sat) return (s > maxv) ? maxv : ((s < minv) ? minv : s);
        t = s <<< (64 - w);
        return t >>> (64 - w);
    endfunction

    task automatic push_expected(input int klen, input bit mode);
        for (int v = 0; v < 3; v++) begin
            for (int r = 0; r < R; r++) begin
                row_t   e;
                longint acc;
                e = '0;
                for (int c = 0; c < C; c++) begin
                    acc = mode ? longint'(tc[r][c]) : 64'sd0;
                    for (int k = 0; k < klen; k++)
                        acc = step(acc, longint'(ta[k][r]) * longint'(tb[k][c]), (v == 0) ? AW : AWS, v == 1);
                    e.v[c*64 +: 64] = acc;
                end
                e.last = (r == R - 1);
                if (v == 0) q_m.push_back(e);
                else if (v == 1) q_s.push_back(e);
                else q_w.push_back(e);
            end
        end
    endtask

    function automatic logic [C*64-1:0] widen32(input logic [C*AW-1:0] d);
        logic [C*64-1:0] w;
        for (int c = 0; c < C; c++) w[c*64 +: 64] = 64'($signed(d[c*AW +: AW]));
        return w;
    endfunction

    function automatic logic [C*64-1:0] widen16(input logic [C*AWS-1:0] d);
        logic [C*64-1:0] w;
        for (int c = 0; c < C; c++) w[c*64 +: 64] = 64'($signed(d[c*AWS +: AWS]));
        return w;
    endfunction

    task automatic cmp_row(input string who, input row_t e, input logic [C*64-1:0] got, input logic got_last);
        for (int c = 0; c < C; c++)
            check($sformatf("%s_c%0d", who, c), got[c*64 +: 64], e.v[c*64 +: 64]);
        check({who, "_last"}, got_last, e.last);
    endtask

    always @(negedge clk) begin
        if (valid_m && res_ready) begin
            if (q_m.size() == 0) check("extra_row_m", 1, 0);
            else cmp_row("row_m", q_m.pop_front(), widen32(data_m), last_m);
        end
        if (valid_s && res_ready) begin
            if (q_s.size() == 0) check("extra_row_s", 1, 0);
            else cmp_row("row_s", q_s.pop_front(), widen16(data_s), last_s);
        end
        if (valid_w && res_ready) begin
            if (q_w.size() == 0) check("extra_row_w", 1, 0);
            else cmp_row("row_w", q_w.pop_front(), widen16(data_w), last_w);
        end
    end

    task automatic send_c(input int r);
        bit got = 0;
        for (int c = 0; c < C; c++) begin
            c_data[c*AW +: AW]     = AW'(tc[r][c]);
            c_data16[c*AWS +: AWS] = AWS'(tc[r][c]);
        end
        c_valid = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (c_rdy_m) got = 1;
            @(posedge clk); #1;
        end
        if (!got) check("c_accept_timeout", 0, 1);
        c_valid = 1'b0;
    endtask

    task automatic send_beat(input int k, input bit last, input bit mismatch);
        bit got = 0;
        for (int r = 0; r < R; r++) a_data[r*DW +: DW] = DW'(ta[k][r]);
        for (int c = 0; c < C; c++) b_data[c*DW +: DW] = DW'(tb[k][c]);
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_done  = last;
        b_done  = last && !mismatch;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (a_rdy_m && b_rdy_m) begin
                got   = 1;
                t_acc = cyc;
            end
            @(posedge clk); #1;
        end
        if (!got) check("beat_accept_timeout", 0, 1);
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_done  = 1'b0;
        b_done  = 1'b0;
    endtask

    task automatic run_tile(input int klen, input bit mode, input bit mismatch, input bit stress);
        acc_mode  = mode;
        res_ready = !stress;
        push_expected(klen, mode);
        if (mismatch) err_exp = 1'b1;
        if (mode) for (int r = 0; r < R; r++) send_c(r);
        if (stress) begin
            c_data   = '1;
            c_data16 = '1;
            c_valid  = 1'b1;
        end
        for (int k = 0; k < klen; k++) begin
            if (stress) begin
                for (int r = 0; r < R; r++) a_data[r*DW +: DW] = DW'(ta[k][r]);
                a_valid = 1'b1;
                b_valid = 1'b0;
                @(posedge clk); #1;
            end
            send_beat(k, k == klen - 1, mismatch);
        end
        if (stress) begin
            a_data  = '1;
            b_data  = '1;
            a_valid = 1'b1;
            b_valid = 1'b1;
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                check("flush_a_ready", a_rdy_m, 0);
                check("flush_c_ready", c_rdy_m, 0);
                @(posedge clk); #1;
            end
            a_valid = 1'b0;
            b_valid = 1'b0;
            c_valid = 1'b0;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid_m) break;
        end
        check("latency", cyc - t_acc, R + C);
        if (stress) begin
            for (int i = 0; i < 5; i++) begin
                if (i > 0) @(negedge clk);
                check("hold_valid", valid_m, 1);
                check("hold_last", last_m, 0);
                for (int c = 0; c < C; c++)
                    check("hold_data", 64'($signed(data_m[c*AW +: AW])), q_m[0].v[c*64 +: 64]);
            end
            @(posedge clk); #1;
            res_ready = 1'b1;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (q_m.size() == 0 && q_s.size() == 0 && q_w.size() == 0 && !busy_m) break;
        end
        check("rows_left_m", q_m.size(), 0);
        check("rows_left_s", q_s.size(), 0);
        check("rows_left_w", q_w.size(), 0);
        check("valid_after", valid_m, 0);
        check("busy_after", busy_m, 0);
        check("err_m", err_m, err_exp);
        check("err_s", err_s, err_exp);
        @(posedge clk); #1;
    endtask

    task automatic set_tile1();
        ta[0][0] = 1; ta[0][1] = 3; ta[1][0] = 2; ta[1][1] = 4;
        tb[0][0] = 5; tb[0][1] = 6; tb[1][0] = 7; tb[1][1] = 8;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a_ready"}, a_rdy_m, 0);
        check({tag, "_b_ready"}, b_rdy_m, 0);
        check({tag, "_c_ready"}, c_rdy_m, 0);
        check({tag, "_valid"}, valid_m, 0);
        check({tag, "_last"}, last_m, 0);
        check({tag, "_data"}, data_m, 0);
        check({tag, "_busy"}, busy_m, 0);
        check({tag, "_err"}, err_m, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        acc_mode = 1'b0; a_valid = 1'b0; a_done = 1'b0; b_valid = 1'b0; b_done = 1'b0;
        c_valid = 1'b0; res_ready = 1'b1;
        a_data = '0; b_data = '0; c_data = '0; c_data16 = '0;
        @(posedge clk); #1;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        set_tile1();
        run_tile(2, 1'b0, 1'b0, 1'b0);

        tc[0][0] = 1; tc[0][1] = 1; tc[1][0] = 2; tc[1][1] = 2;
        run_tile(2, 1'b1, 1'b0, 1'b0);

        ta[0][0] = -128; ta[0][1] = -128;
        tb[0][0] = -128; tb[0][1] = 127;
        run_tile(1, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < R; r++) ta[k][r] = 127;
            for (int c = 0; c < C; c++) tb[k][c] = 127;
        end
        run_tile(3, 1'b0, 1'b0, 1'b0);

        set_tile1();
        run_tile(2, 1'b0, 1'b0, 1'b1);

        for (int t = 0; t < 4; t++) begin
            int klen;
            klen = $urandom_range(1, 6);
            for (int k = 0; k < klen; k++) begin
                for (int r = 0; r < R; r++) ta[k][r] = int'($urandom_range(0, 255)) - 128;
                for (int c = 0; c < C; c++) tb[k][c] = int'($urandom_range(0, 255)) - 128;
            end
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++) tc[r][c] = int'($urandom_range(0, 2000)) - 1000;
            run_tile(klen, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        set_tile1();
        run_tile(2, 1'b0, 1'b1, 1'b0);

        acc_mode = 1'b0;
        send_beat(0, 1'b0, 1'b0);
        check("busy_mid_stream", busy_m, 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("abort");
        err_exp = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_tile(2, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/systolic_array_os.md
Name: systolic_array_os

Overview:
- Parametrised output-stationary ROWS x COLS signed-integer systolic array. Second generation of the simulation-only matrix engine.
- Each tile computes C_out = A * B or C_out = A * B + C_in.
  - A arrives as K column slices of ROWS elements each.
  - B arrives as K row slices of COLS elements each.
  - C_in bias rows are optional.
- Adds the following: parametrised geometry, internal input skewing, bias preload mode, optional saturation, a drained result stream with back-pressure, and a protocol error flag.
- Sits between the matrix slice fetchers and the spike/attention post-processing stage.

Parameters:
- ROWS, 4, PE rows, which is the number of A elements per slice (>=1).
- COLS, 4, PE columns, which is the number of B elements per slice (>=1).
- DATA_W, 8, signed width of each A and B element.
- ACC_W, 32, signed accumulator and result element width (>= 2*DATA_W).
- SATURATE, 0, selects accumulator overflow handling: 1 = clamp to the signed ACC_W range, 0 = two's-complement wrap.

Ports:
- s_clk  in  1  clock; all logic is on the rising edge.
- s_rst  in  1  asynchronous, active-low reset.
- acc_mode  in  1  0 = clear accumulators, 1 = preload from C. Sampled in IDLE on the first A/B or C accept.
- MtrxA_slice_valid  in  1  A slice valid.
- MtrxA_slice_data  in  ROWS*DATA_W  A column slice; lane r = A[r][k], lane 0 in the LSBs.
- MtrxA_slice_done  in  1  marks the last A slice of the tile.
- MtrxA_slice_ready  out  1  A slice accepted when valid and ready are both high.
- MtrxB_slice_valid  in  1  B slice valid.
- MtrxB_slice_data  in  COLS*DATA_W  B row slice; lane c = B[k][c].
- MtrxB_slice_done  in  1  marks the last B slice of the tile.
- MtrxB_slice_ready  out  1  B slice ready.
- MtrxC_slice_valid  in  1  C bias row valid.
- MtrxC_slice_data  in  COLS*ACC_W  one bias row; rows arrive in order 0..ROWS-1.
- MtrxC_slice_ready  out  1  C bias row ready.
- Result_valid  out  1  result row valid.
- Result_data  out  COLS*ACC_W  one result row; lane c = C[r][c].
- Result_last  out  1  high on row ROWS-1.
- Result_ready  in  1  downstream ready.
- busy  out  1  high whenever the state is not IDLE.
- err  out  1  sticky; set on a done mismatch; cleared only by reset.

Behaviour:
- Reset (s_rst low, asynchronous): state IDLE; all accumulators, skew registers and counters cleared. Every output is 0, including all ready signals, Result_valid, Result_last, Result_data, busy and err.
- IDLE:
  - MtrxA_slice_ready = MtrxB_slice_ready = !acc_mode.
  - MtrxC_slice_ready = acc_mode.
  - If acc_mode = 1: go to LOAD_C on the first C accept.
  - If acc_mode = 0: go to STREAM on the first A/B accept; that beat is processed and accumulators start from zero.
- LOAD_C:
  - Accept ROWS C rows; row r is written into PE row r.
  - After the ROWS-th accept, go to STREAM.
  - A/B ready stays low until then.
- STREAM:
  - MtrxA_slice_ready = MtrxB_slice_ready = 1.
  - A beat is consumed only when A valid and B valid are both high; a single valid side is never consumed.
  - Input skew: A lane r is delayed r cycles and B lane c is delayed c cycles. Bubbles (cycles without a consume) inject zeros.
  - Each PE does acc += a*b.
    - The product is a full 2*DATA_W signed value, sign-extended to ACC_W.
    - With SATURATE = 1, the sum is clamped to the range -2^(ACC_W-1) .. 2^(ACC_W-1)-1.
  - On the consumed beat where either done is high, go to FLUSH.
  - If the two done bits differ on that beat, set err; the tile still completes.
- FLUSH:
  - Lasts exactly ROWS+COLS-1 cycles; all input readies are low.
  - Then go to OUTPUT.
- OUTPUT:
  - Rows are emitted 0..ROWS-1, one per Result_valid && Result_ready handshake.
  - Result_valid is asserted on the first OUTPUT cycle.
  - Result_data and Result_last are held stable while Result_valid is high and Result_ready is low.
  - After the last handshake: Result_valid drops the next cycle and the state returns to IDLE. Accumulators are cleared on that transition.
- Latency:
  - Last A/B accept at cycle t gives Result_valid at cycle t+ROWS+COLS.
  - Minimum tile occupancy is K + ROWS+COLS-1 + ROWS cycles, plus ROWS cycles when acc_mode = 1.
- Boundary conditions:
  - K = 1 (done on the first beat) is legal.
  - No limit on K; only the accumulator width bounds it.
  - Inputs asserted in FLUSH or OUTPUT are not accepted; ready stays low.
  - C traffic in STREAM is ignored.
  - Reset asserted mid-tile aborts immediately; the next tile starts clean.

Test Plan:
- ROWS = COLS = 2, DATA_W = 8, ACC_W = 32, acc_mode = 0.
  - Stimulus: A slices {1,3},{2,4}; B slices {5,6},{7,8}; done on beat 2.
  - Required: rows {19,22},{43,50}; Result_last on row 1; Result_valid exactly 4 cycles after the last accept.
- Same tile with acc_mode = 1 and C rows {1,1},{2,2}.
  - Required: {20,23},{45,52}.
- Signed extremes, K = 1: A = {-128,-128}, B = {-128,127}.
  - Required: rows {16384,-16256},{16384,-16256}.
- ACC_W = 16, K = 3, all elements 127.
  - SATURATE = 1: every element 32767.
  - SATURATE = 0: every element -17149.
- Back-pressure and bubbles:
  - Toggle B valid 1/0 during STREAM, then hold Result_ready low for 5 cycles in OUTPUT.
  - Required: results identical to the first scenario; data held stable; no row lost or duplicated.
- Protocol:
  - A done on beat 2 with B done low: err = 1 and the tile still outputs.
  - Drop s_rst mid-STREAM: all outputs 0 immediately; the following clean tile is correct with err = 0.
